// File: rtl/uart_boot_loader.sv
// uart_boot_loader: parses framed load packets from the UART RX queue, writes the
// payload words over the femto bus and answers every packet with ACK/NAK.
`ifndef BUS_ACC_CNT
`define BUS_ACC_CNT 3
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2
`endif

module uart_boot_loader #(
  parameter int unsigned TIMEOUT_CYC = 120000,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter logic [7:0]  ACK_BYTE    = 8'h06,
  parameter logic [7:0]  NAK_BYTE    = 8'h15
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           enable,
  input  logic                           rxq_empty,
  input  logic [7:0]                     recv_data,
  output logic                           recv_resp,
  input  logic                           txq_full,
  output logic                           send_req,
  output logic [7:0]                     send_data,
  output logic                           bus_req,
  output logic                           bus_wr_b,
  output logic [$clog2(`BUS_ACC_CNT)-1:0] bus_acc,
  output logic [31:0]                    bus_addr,
  output logic [31:0]                    bus_wdata,
  input  logic                           bus_resp,
  input  logic                           bus_fault,
  output logic                           busy,
  output logic                           boot_done,
  output logic [31:0]                    boot_addr
);

  localparam int AW = $clog2(`BUS_ACC_CNT);
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_JUMP  = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_LEN, S_DATA, S_WRITE, S_CSUM, S_ACK
  } state_t;

  state_t      state_q, state_d;
  logic        run_q, err_q, err_d, pend_q, pend_d;
  logic [7:0]  cmd_q, cmd_d, csum_q, csum_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] len_q, len_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, tmo_q, tmo_d;
  logic        bus_req_q, bus_req_d, send_req_q, send_req_d, boot_done_q, boot_done_d;
  logic [7:0]  send_data_q, send_data_d;
  logic [31:0] boot_addr_q, boot_addr_d;

  logic        byte_st, tmo_st, tmo_hit, bus_done;
  logic [7:0]  csum_nx;
  logic [15:0] len_full;

  assign csum_nx  = csum_q + recv_data;
  assign len_full = {recv_data, len_q[15:8]};
  // Fault completes the access in the request cycle; otherwise wait for bus_resp.
  assign bus_done = pend_q && (bus_resp || (bus_req_q && bus_fault));
  assign byte_st  = (state_q inside {S_IDLE, S_CMD, S_ADDR, S_LEN, S_DATA, S_CSUM});
  assign tmo_st   = (state_q inside {S_CMD, S_ADDR, S_LEN, S_DATA, S_CSUM});
  assign tmo_hit  = (TIMEOUT_CYC != 0) && tmo_st && rxq_empty && (tmo_q + 32'd1 == TIMEOUT_CYC);

  assign send_req  = send_req_q;
  assign send_data = send_data_q;
  assign bus_req   = bus_req_q;
  assign bus_wr_b  = bus_req_q;
  assign bus_acc   = bus_req_q ? AW'(`BUS_ACC_4B) : '0;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign boot_done = boot_done_q;
  assign boot_addr = boot_addr_q;

  // Next-state and datapath: one byte consumed per cycle in byte states; the pop is
  // combinational because a registered pop could not know whether the next byte exists.
  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    pend_d      = pend_q && !bus_done;
    cmd_d       = cmd_q;
    csum_d      = csum_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    tmo_d       = (tmo_st && rxq_empty) ? tmo_q + 32'd1 : 32'd0;
    bus_req_d   = 1'b0;
    send_req_d  = 1'b0;
    send_data_d = send_data_q;
    boot_done_d = boot_done_q;
    boot_addr_d = boot_addr_q;
    recv_resp   = 1'b0;
    if (!enable) begin
      // Never abandon an in-flight bus access; everything else aborts at once.
      if (!(state_q == S_WRITE && pend_q && !bus_done)) state_d = S_IDLE;
    end else if (tmo_hit) begin
      state_d = S_IDLE;
    end else begin
      if (run_q && byte_st && !rxq_empty) recv_resp = 1'b1;
      case (state_q)
        S_IDLE: if (recv_resp && recv_data == SYNC_BYTE) begin
          state_d = S_CMD;
          err_d   = 1'b0;
          csum_d  = 8'h00;
          cnt_d   = 2'd0;
        end
        S_CMD: if (recv_resp) begin
          cmd_d   = recv_data;
          csum_d  = csum_nx;
          if (recv_data != CMD_WRITE && recv_data != CMD_JUMP) err_d = 1'b1;
          state_d = S_ADDR;
        end
        S_ADDR: if (recv_resp) begin
          addr_d = {recv_data, addr_q[31:8]};
          csum_d = csum_nx;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_LEN;
            cnt_d   = 2'd0;
          end
        end
        S_LEN: if (recv_resp) begin
          len_d  = len_full;
          csum_d = csum_nx;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd1) begin
            if (addr_q[1:0] != 2'b00) err_d = 1'b1;
            if (cmd_q == CMD_JUMP && len_full != 16'd0) err_d = 1'b1;
            state_d = (len_full != 16'd0) ? S_DATA : S_CSUM;
            cnt_d   = 2'd0;
          end
        end
        S_DATA: if (recv_resp) begin
          wdata_d = {recv_data, wdata_q[31:8]};
          csum_d  = csum_nx;
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d   = S_WRITE;
            bus_req_d = !err_q;
            pend_d    = !err_q;
          end
        end
        S_WRITE: begin
          if (bus_req_q && bus_fault) err_d = 1'b1;
          if (!pend_q || bus_done) begin
            addr_d  = addr_q + 32'd4;
            len_d   = len_q - 16'd1;
            cnt_d   = 2'd0;
            state_d = (len_q == 16'd1) ? S_CSUM : S_DATA;
          end
        end
        S_CSUM: if (recv_resp) begin
          if (csum_nx != 8'h00) err_d = 1'b1;
          state_d = S_ACK;
        end
        S_ACK: if (!txq_full) begin
          send_req_d  = 1'b1;
          send_data_d = err_q ? NAK_BYTE : ACK_BYTE;
          if (!err_q && cmd_q == CMD_JUMP) begin
            boot_done_d = 1'b1;
            boot_addr_d = addr_q;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      run_q       <= 1'b0;
      err_q       <= 1'b0;
      pend_q      <= 1'b0;
      cmd_q       <= 8'h00;
      csum_q      <= 8'h00;
      cnt_q       <= 2'd0;
      len_q       <= 16'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      tmo_q       <= 32'd0;
      bus_req_q   <= 1'b0;
      send_req_q  <= 1'b0;
      send_data_q <= 8'h00;
      boot_done_q <= 1'b0;
      boot_addr_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      run_q       <= 1'b1;
      err_q       <= err_d;
      pend_q      <= pend_d;
      cmd_q       <= cmd_d;
      csum_q      <= csum_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      tmo_q       <= tmo_d;
      bus_req_q   <= bus_req_d;
      send_req_q  <= send_req_d;
      send_data_q <= send_data_d;
      boot_done_q <= boot_done_d;
      boot_addr_q <= boot_addr_d;
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: RX queue, TX queue and bus are modelled here.
`ifndef BUS_ACC_CNT
`define BUS_ACC_CNT 3
`endif

module tb_uart_boot_loader;
  localparam int TMO = 300;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b1;
  logic        rxq_empty, recv_resp, send_req, bus_req, bus_wr_b, bus_fault, busy, boot_done;
  logic        txq_full = 1'b0;
  logic        bus_resp = 1'b0;
  logic [7:0]  recv_data, send_data;
  logic [$clog2(`BUS_ACC_CNT)-1:0] bus_acc;
  logic [31:0] bus_addr, bus_wdata, boot_addr;

  uart_boot_loader #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .rxq_empty(rxq_empty), .recv_data(recv_data),
    .recv_resp(recv_resp), .txq_full(txq_full), .send_req(send_req), .send_data(send_data),
    .bus_req(bus_req), .bus_wr_b(bus_wr_b), .bus_acc(bus_acc), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_resp(bus_resp), .bus_fault(bus_fault), .busy(busy),
    .boot_done(boot_done), .boot_addr(boot_addr)
  );

  always #5 clk = ~clk;

  // RX queue model (FWFT)
  logic [7:0] rxb [0:1023];
  int wr = 0;
  int rd = 0;
  assign rxq_empty = (rd == wr);
  assign recv_data = rxb[rd[9:0]];
  always @(posedge clk or negedge rstn)
    if (!rstn) rd <= wr;
    else if (recv_resp) rd <= rd + 1;

  // TX and bus monitors, bus responder
  logic [7:0]  txlog [0:63];
  logic [31:0] wa [0:63];
  logic [31:0] wd [0:63];
  int txcnt = 0;
  int bcnt = 0;
  int badattr = 0;
  int fault_idx = -1;
  assign bus_fault = bus_req && (bcnt == fault_idx);
  always @(posedge clk) begin
    if (send_req) begin txlog[txcnt[5:0]] <= send_data; txcnt <= txcnt + 1; end
    if (bus_req) begin
      wa[bcnt[5:0]] <= bus_addr;
      wd[bcnt[5:0]] <= bus_wdata;
      bcnt <= bcnt + 1;
      if (!bus_wr_b || bus_acc != 2'd2) badattr <= badattr + 1;
    end
    bus_resp <= bus_req && !bus_fault;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    rxb[wr[9:0]] = b;
    wr = wr + 1;
  endtask

  task automatic send_pkt(input logic [7:0] cmd, input logic [31:0] addr, input logic [15:0] nw,
                          input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                          input logic [7:0] adj);
    logic [7:0]  s;
    logic [31:0] w;
    push(8'hA5);
    push(cmd);
    s = cmd;
    for (int i = 0; i < 4; i++) begin push(addr[8*i +: 8]); s = s + addr[8*i +: 8]; end
    push(nw[7:0]);  s = s + nw[7:0];
    push(nw[15:8]); s = s + nw[15:8];
    for (int k = 0; k < int'(nw); k++) begin
      w = (k == 0) ? w0 : (k == 1) ? w1 : w2;
      for (int i = 0; i < 4; i++) begin push(w[8*i +: 8]); s = s + w[8*i +: 8]; end
    end
    push((8'h00 - s) + adj);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy || rd != wr) && n < 3000) begin @(negedge clk); n++; end
    chk({tag, "_done"}, 32'(n < 3000), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic out_zero(input string tag);
    chk({tag, "_ctl"}, {26'd0, recv_resp, send_req, bus_req, bus_wr_b, busy, boot_done}, 32'd0);
    chk({tag, "_acc"}, 32'(bus_acc), 32'd0);
    chk({tag, "_sdata"}, 32'(send_data), 32'd0);
    chk({tag, "_baddr"}, bus_addr, 32'd0);
    chk({tag, "_bwdata"}, bus_wdata, 32'd0);
    chk({tag, "_bootaddr"}, boot_addr, 32'd0);
  endtask

  int b0, t0;

  initial begin
    repeat (3) @(negedge clk);
    out_zero("reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // T1 good write
    b0 = bcnt; t0 = txcnt;
    send_pkt(8'h01, 32'h0000_1000, 16'd1, 32'hDEAD_BEEF, 32'd0, 32'd0, 8'h00);
    wait_idle("t1");
    chk("t1_nwr", 32'(bcnt - b0), 32'd1);
    chk("t1_addr", wa[b0[5:0]], 32'h0000_1000);
    chk("t1_data", wd[b0[5:0]], 32'hDEAD_BEEF);
    chk("t1_ntx", 32'(txcnt - t0), 32'd1);
    chk("t1_reply", 32'(txlog[t0[5:0]]), 32'h06);

    // T2 bad checksum: write still goes out, NAK
    b0 = bcnt; t0 = txcnt;
    send_pkt(8'h01, 32'h0000_1000, 16'd1, 32'hDEAD_BEEF, 32'd0, 32'd0, 8'h01);
    wait_idle("t2");
    chk("t2_nwr", 32'(bcnt - b0), 32'd1);
    chk("t2_addr", wa[b0[5:0]], 32'h0000_1000);
    chk("t2_reply", 32'(txlog[t0[5:0]]), 32'h15);
    chk("t2_bootdone", 32'(boot_done), 32'd0);

    // T3 jump: A5 02 00 00 00 80 00 00 7E
    t0 = txcnt;
    send_pkt(8'h02, 32'h8000_0000, 16'd0, 32'd0, 32'd0, 32'd0, 8'h00);
    wait_idle("t3");
    chk("t3_reply", 32'(txlog[t0[5:0]]), 32'h06);
    chk("t3_bootdone", 32'(boot_done), 32'd1);
    chk("t3_bootaddr", boot_addr, 32'h8000_0000);

    // T4 junk then a stalled packet header
    b0 = bcnt; t0 = txcnt;
    push(8'h11); push(8'h22); push(8'h33); push(8'hA5); push(8'h01);
    repeat (20) @(negedge clk);
    chk("t4_busy_stall", 32'(busy), 32'd1);
    repeat (TMO + 10) @(negedge clk);
    chk("t4_busy_tmo", 32'(busy), 32'd0);
    chk("t4_nwr", 32'(bcnt - b0), 32'd0);
    chk("t4_ntx", 32'(txcnt - t0), 32'd0);
    chk("t4_bootdone", 32'(boot_done), 32'd1);

    // T5 bus fault on word 2 of 3
    b0 = bcnt; t0 = txcnt;
    fault_idx = bcnt + 1;
    send_pkt(8'h01, 32'h0000_2000, 16'd3, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 8'h00);
    wait_idle("t5");
    fault_idx = -1;
    chk("t5_nwr", 32'(bcnt - b0), 32'd2);
    chk("t5_addr0", wa[b0[5:0]], 32'h0000_2000);
    chk("t5_addr1", wa[6'(b0 + 1)], 32'h0000_2004);
    chk("t5_reply", 32'(txlog[t0[5:0]]), 32'h15);

    // T5 backpressure on the reply
    t0 = txcnt;
    txq_full = 1'b1;
    send_pkt(8'h01, 32'h0000_3000, 16'd0, 32'd0, 32'd0, 32'd0, 8'h00);
    repeat (50) @(negedge clk);
    chk("t5_bp_ntx", 32'(txcnt - t0), 32'd0);
    chk("t5_bp_busy", 32'(busy), 32'd1);
    txq_full = 1'b0;
    wait_idle("t5_bp");
    chk("t5_bp_ntx2", 32'(txcnt - t0), 32'd1);
    chk("t5_bp_reply", 32'(txlog[t0[5:0]]), 32'h06);

    // T6 address wrap
    b0 = bcnt; t0 = txcnt;
    send_pkt(8'h01, 32'hFFFF_FFFC, 16'd2, 32'hA1A1_A1A1, 32'hB2B2_B2B2, 32'd0, 8'h00);
    wait_idle("t6w");
    chk("t6w_nwr", 32'(bcnt - b0), 32'd2);
    chk("t6w_addr0", wa[b0[5:0]], 32'hFFFF_FFFC);
    chk("t6w_addr1", wa[6'(b0 + 1)], 32'h0000_0000);
    chk("t6w_data1", wd[6'(b0 + 1)], 32'hB2B2_B2B2);
    chk("t6w_reply", 32'(txlog[t0[5:0]]), 32'h06);

    // T6 unaligned address
    b0 = bcnt; t0 = txcnt;
    send_pkt(8'h01, 32'h0000_1002, 16'd1, 32'h1234_5678, 32'd0, 32'd0, 8'h00);
    wait_idle("t6u");
    chk("t6u_nwr", 32'(bcnt - b0), 32'd0);
    chk("t6u_reply", 32'(txlog[t0[5:0]]), 32'h15);

    // T6 reset in the middle of DATA
    t0 = txcnt;
    push(8'hA5); push(8'h01); push(8'h00); push(8'h40); push(8'h00); push(8'h00);
    push(8'h01); push(8'h00); push(8'h11); push(8'h22);
    repeat (20) @(negedge clk);
    chk("t6r_busy", 32'(busy), 32'd1);
    #2 rstn = 1'b0;
    #1 out_zero("t6r_async");
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6r_idle", 32'(busy), 32'd0);
    chk("t6r_ntx", 32'(txcnt - t0), 32'd0);

    chk("bus_attr", 32'(badattr), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
